// File: rtl/delay_probe_ctrl.sv
// Delay-path measurement controller: launches path edges, times the synchronized
// response against the datapath counter, and accumulates last/min/max/sum per run.
module delay_probe_ctrl #(
   parameter int TIMEOUT = 1023,
   parameter int SETTLE  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  trials,
   output logic        ld,
   output logic        pathInput,
   input  logic        pathResult,
   input  logic [31:0] result,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [31:0] delay_last,
   output logic [31:0] delay_min,
   output logic [31:0] delay_max,
   output logic [39:0] delay_sum,
   output logic [7:0]  trials_done
);

   localparam int SettleW = $clog2(SETTLE + 1);
   localparam int WaitW   = $clog2(TIMEOUT + 1);
   localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE - 1);
   localparam logic [WaitW-1:0]   WaitLast   = WaitW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      sIdle,
      sSettle,
      sLaunch,
      sWait,
      sAccum,
      sDone
   } state_t;

   state_t             state;
   logic               ps1;
   logic               ps2;
   logic               base;
   logic [31:0]        snap0;
   logic [31:0]        delta;
   logic [7:0]         trialsReq;
   logic [SettleW-1:0] settleCnt;
   logic [WaitW-1:0]   waitCnt;
   logic [7:0]         trialsDoneNext;

   assign trialsDoneNext = trials_done + 8'd1;

   // NOTE: every register here is updated with <= so all branches see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= sIdle;
         ps1         <= 1'b0;
         ps2         <= 1'b0;
         base        <= 1'b0;
         snap0       <= '0;
         delta       <= '0;
         trialsReq   <= '0;
         settleCnt   <= '0;
         waitCnt     <= '0;
         ld          <= 1'b0;
         pathInput   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         delay_last  <= '0;
         delay_min   <= '0;
         delay_max   <= '0;
         delay_sum   <= '0;
         trials_done <= '0;
      end else begin
         ps1  <= pathResult;
         ps2  <= ps1;
         done <= 1'b0;
         case (state)
            sIdle: begin
               if (start) begin
                  busy        <= 1'b1;
                  timeout     <= 1'b0;
                  delay_last  <= '0;
                  delay_min   <= '1;
                  delay_max   <= '0;
                  delay_sum   <= '0;
                  trials_done <= '0;
                  trialsReq   <= (trials == 8'd0) ? 8'd1 : trials;
                  settleCnt   <= '0;
                  state       <= sSettle;
               end
            end
            sSettle: begin
               if (settleCnt == SettleLast) begin
                  base  <= ps2;
                  state <= sLaunch;
               end else begin
                  settleCnt <= settleCnt + SettleW'(1);
               end
            end
            sLaunch: begin
               pathInput <= ~pathInput;
               ld        <= 1'b1;
               snap0     <= result;
               waitCnt   <= '0;
               state     <= sWait;
            end
            sWait: begin
               // A response edge seen on the final wait cycle still counts as a measurement.
               if (ps2 != base) begin
                  delta <= result - snap0;
                  ld    <= 1'b0;
                  state <= sAccum;
               end else if (waitCnt == WaitLast) begin
                  timeout <= 1'b1;
                  ld      <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= sDone;
               end else begin
                  waitCnt <= waitCnt + WaitW'(1);
               end
            end
            sAccum: begin
               delay_last  <= delta;
               delay_sum   <= delay_sum + {8'd0, delta};
               trials_done <= trialsDoneNext;
               if (delta < delay_min) delay_min <= delta;
               if (delta > delay_max) delay_max <= delta;
               if (trialsDoneNext == trialsReq) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= sDone;
               end else begin
                  settleCnt <= '0;
                  state     <= sSettle;
               end
            end
            sDone: begin
               state <= sIdle;
            end
            default: begin
               state <= sIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_delay_probe_ctrl.sv
// Scoreboard bench for delay_probe_ctrl: behavioral delay path and free-running counter,
// expected run results queued at start and compared on each done pulse.
module tb_delay_probe_ctrl;

   localparam int SETTLE  = 16;
   localparam int TIMEOUT = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  trials;
   logic        ld;
   logic        pathInput;
   logic        pathResult;
   logic [31:0] result;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [31:0] delay_last;
   logic [31:0] delay_min;
   logic [31:0] delay_max;
   logic [39:0] delay_sum;
   logic [7:0]  trials_done;

   delay_probe_ctrl #(.TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .start(start), .trials(trials), .ld(ld),
      .pathInput(pathInput), .pathResult(pathResult), .result(result),
      .busy(busy), .done(done), .timeout(timeout), .delay_last(delay_last),
      .delay_min(delay_min), .delay_max(delay_max), .delay_sum(delay_sum),
      .trials_done(trials_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] last;
      logic [31:0] mn;
      logic [31:0] mx;
      logic [39:0] sum;
      logic [7:0]  cnt;
      logic        to;
      logic        pi;
   } exp_t;

   exp_t sbQ[$];
   logic piModel = 1'b0;

   // Datapath model: enabled counter plus a tapped shift-register delay line.
   logic [31:0] cnt = '0;
   logic [7:0]  shift = '0;
   logic [7:0]  launchIdx = '0;
   logic        cntLoad = 1'b0;
   logic [31:0] cntLoadVal = '0;
   int          dOdd = 3;
   int          dEven = 3;
   logic        stuck = 1'b0;
   logic [2:0]  tap;

   assign result = cnt;
   always_comb tap = 3'((launchIdx[0] ? dOdd : dEven) - 1);
   assign pathResult = stuck ? 1'b0 : shift[tap];

   always @(posedge clk) begin
      if (cntLoad) cnt <= cntLoadVal;
      else if (ld) cnt <= cnt + 32'd1;
      if (cntLoad) launchIdx <= '0;
      else if (pathInput != shift[0]) launchIdx <= launchIdx + 8'd1;
      shift <= {shift[6:0], pathInput};
   end

   task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic setupPath(input int o, input int e, input logic s, input logic [31:0] pre);
      @(negedge clk);
      dOdd       = o;
      dEven      = e;
      stuck      = s;
      cntLoad    = 1'b1;
      cntLoadVal = pre;
      @(negedge clk);
      cntLoad = 1'b0;
   endtask

   // Odd-numbered trials of a run see delay o, even-numbered ones delay e; +2 for the synchronizer.
   task automatic pushExp(input int n, input int o, input int e, input bit s);
      exp_t        x;
      int          eff;
      logic [31:0] d;
      eff   = (n == 0) ? 1 : n;
      x.last = '0;
      x.mn   = '1;
      x.mx   = '0;
      x.sum  = '0;
      x.cnt  = '0;
      x.to   = 1'b0;
      if (s) begin
         x.to    = 1'b1;
         piModel = ~piModel;
      end else begin
         for (int i = 1; i <= eff; i++) begin
            d      = 32'((((i % 2) == 1) ? o : e) + 2);
            x.last = d;
            x.sum  = x.sum + {8'd0, d};
            if (d < x.mn) x.mn = d;
            if (d > x.mx) x.mx = d;
            x.cnt   = x.cnt + 8'd1;
            piModel = ~piModel;
         end
      end
      x.pi = piModel;
      sbQ.push_back(x);
   endtask

   task automatic startRun(input logic [7:0] n);
      @(negedge clk);
      start  = 1'b1;
      trials = n;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1'b1);
      check("timeout_cleared", timeout, 1'b0);
   endtask

   task automatic waitDone(input int budget, output int ldCyc);
      bit   seen;
      exp_t e;
      seen  = 1'b0;
      ldCyc = 0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (ld) ldCyc++;
         if (done) begin
            seen = 1'b1;
            check("sb_depth", 40'(sbQ.size()), 40'd1);
            if (sbQ.size() != 0) begin
               e = sbQ.pop_front();
               check("delay_last", delay_last, e.last);
               check("delay_min", delay_min, e.mn);
               check("delay_max", delay_max, e.mx);
               check("delay_sum", delay_sum, e.sum);
               check("trials_done", trials_done, e.cnt);
               check("timeout", timeout, e.to);
               check("pathInput", pathInput, e.pi);
               check("busy_at_done", busy, 1'b0);
               check("ld_at_done", ld, 1'b0);
            end
         end
      end
      check("done_seen", seen, 1'b1);
      if (seen) begin
         @(negedge clk);
         check("done_width", done, 1'b0);
      end
   endtask

   initial begin
      int ldCyc;
      int k;
      int nDone;
      logic piPrev;

      rst    = 1'b1;
      start  = 1'b0;
      trials = 8'd0;
      repeat (2) @(negedge clk);
      check("rst_ld", ld, 1'b0);
      check("rst_pathInput", pathInput, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_timeout", timeout, 1'b0);
      check("rst_min", delay_min, 32'd0);
      check("rst_sum", delay_sum, 40'd0);
      check("rst_trials_done", trials_done, 8'd0);
      rst = 1'b0;

      // Multi-trial with alternating 2/6-cycle path delays.
      setupPath(2, 6, 1'b0, 32'd1000);
      pushExp(4, 2, 6, 1'b0);
      startRun(8'd4);
      waitDone(2000, ldCyc);

      // Single trial, counter starting at 100.
      setupPath(3, 3, 1'b0, 32'd100);
      pushExp(1, 3, 3, 1'b0);
      startRun(8'd1);
      waitDone(2000, ldCyc);

      // Counter wraps between launch and capture.
      setupPath(3, 3, 1'b0, 32'hFFFF_FFFE);
      pushExp(1, 3, 3, 1'b0);
      startRun(8'd1);
      waitDone(2000, ldCyc);

      // Stuck path: the first trial times out after TIMEOUT wait cycles.
      setupPath(3, 3, 1'b1, 32'd0);
      pushExp(3, 3, 3, 1'b1);
      startRun(8'd3);
      waitDone(2000, ldCyc);
      check("timeout_wait_cycles", 40'(ldCyc), 40'(TIMEOUT));

      // trials=0 runs once; the accepted start clears timeout.
      setupPath(3, 3, 1'b0, 32'd500);
      pushExp(0, 3, 3, 1'b0);
      startRun(8'd0);
      waitDone(2000, ldCyc);

      // Start during SETTLE is ignored; also measures launch latency.
      setupPath(3, 3, 1'b0, 32'd0);
      pushExp(2, 3, 3, 1'b0);
      @(negedge clk);
      start  = 1'b1;
      trials = 8'd2;
      piPrev = pathInput;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      while (k < 200 && pathInput == piPrev) begin
         @(negedge clk);
         k++;
         if (k == 5) begin
            start  = 1'b1;
            trials = 8'd7;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check("launch_latency", 40'(k), 40'(SETTLE + 2));
      waitDone(2000, ldCyc);

      // Reset in the middle of WAIT.
      setupPath(8, 8, 1'b0, 32'd0);
      startRun(8'd2);
      k = 0;
      while (k < 200 && !ld) begin
         @(negedge clk);
         k++;
      end
      check("ld_rise", ld, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      piModel = 1'b0;
      check("midrst_ld", ld, 1'b0);
      check("midrst_pathInput", pathInput, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_last", delay_last, 32'd0);
      check("midrst_min", delay_min, 32'd0);
      check("midrst_max", delay_max, 32'd0);
      check("midrst_sum", delay_sum, 40'd0);
      check("midrst_trials_done", trials_done, 8'd0);
      nDone = 0;
      repeat (60) begin
         @(negedge clk);
         if (done) nDone++;
      end
      check("midrst_no_done", 40'(nDone), 40'd0);

      // Recovery run after the abort.
      setupPath(3, 3, 1'b0, 32'd7);
      pushExp(1, 3, 3, 1'b0);
      startRun(8'd1);
      waitDone(2000, ldCyc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
